instr_fetch_unit: RTL and testbench

- Upstream neighbour of the KGP-RISC control unit.
- Owns the PC and fetches 32-bit words from instruction memory over a req/ready handshake.
- Holds the fetched word in an instruction register and splits out opcode/fcode (fed straight to control_unit) plus register and immediate fields.
- Accepts PC redirects from the branch path (branch/reg2PC resolution) and squashes any fetch in flight.

---
 rtl/kgp_isa_pkg.sv | 47 ++++
 rtl/instr_field_decode.sv | 28 ++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_isa_pkg.sv
// kgp_isa_pkg: shared KGP-RISC instruction-set definitions.
//   - opcode constants and the highest defined fcode for each opcode
//   - bit positions of the instruction fields
//   - fetch FSM state encoding
//   - fcode_defined(): encoding legality check shared by decode and checkers
package kgp_isa_pkg;

    localparam logic [1:0] OP_MEM = 2'd0;
    localparam logic [1:0] OP_ALU = 2'd1;
    localparam logic [1:0] OP_IMM = 2'd2;
    localparam logic [1:0] OP_BR  = 2'd3;

    localparam logic [3:0] MAX_FCODE_MEM = 4'd1;
    localparam logic [3:0] MAX_FCODE_ALU = 4'd8;
    localparam logic [3:0] MAX_FCODE_IMM = 4'd4;
    localparam logic [3:0] MAX_FCODE_BR  = 4'd11;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 30;
    localparam int FCODE_MSB  = 29;
    localparam int FCODE_LSB  = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    function automatic logic fcode_defined(input logic [1:0] op, input logic [3:0] fc);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_MEM:  ok = (fc <= MAX_FCODE_MEM);
            OP_ALU:  ok = (fc <= MAX_FCODE_ALU);
            OP_IMM:  ok = (fc <= MAX_FCODE_IMM);
            OP_BR:   ok = (fc <= MAX_FCODE_BR);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational split of a 32-bit KGP-RISC word.
// Ports:
//   instr     in  32  instruction word
//   opcode    out 2   instr[31:30]
//   fcode     out 4   instr[29:26]
//   rs, rt    out 5   register specifiers
//   imm       out 16  immediate field
//   undefined out 1   opcode/fcode pair is not a defined encoding
module instr_field_decode
    import kgp_isa_pkg::*;
(
    input  logic [31:0] instr,
    output logic [1:0]  opcode,
    output logic [3:0]  fcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imm,
    output logic        undefined
);

    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign fcode     = instr[FCODE_MSB:FCODE_LSB];
    assign rs        = instr[RS_MSB:RS_LSB];
    assign rt        = instr[RT_MSB:RT_LSB];
    assign imm       = instr[IMM_MSB:IMM_LSB];
    assign undefined = !fcode_defined(opcode, fcode);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches words over a req/ready handshake,
// holds the word in an instruction register and presents decoded fields to
// the control unit.
// Handshake: a word is taken only in a cycle where imem_req and imem_ready
// are both high; imem_addr is stable for as long as imem_req is high.
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req/addr/ready/rdata instruction memory interface
//   redirect_valid/pc         taken branch/jump target, squashes fetch
//   stall                     downstream cannot take the held instruction
//   instr_valid, instr        held instruction register
//   opcode/fcode/rs/rt/imm    decoded fields of instr
//   pc_out, pc_plus4          address of held instruction and its link value
//   illegal                   held instruction has an undefined encoding
//   fetch_count               instructions delivered downstream (wraps)
module instr_fetch_unit
    import kgp_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    input  logic             stall,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [1:0]       opcode,
    output logic [3:0]       fcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [15:0]      imm,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic             illegal,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_out_q, pc_out_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             undefined;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
            req_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    // Squash: whatever memory returns now belongs to the old
                    // stream; drop req for one cycle so the new address is
                    // presented as a fresh request.
                    pc_d  = redirect_pc;
                    req_d = 1'b0;
                end else if (req_q && imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    req_d    = 1'b0;
                    state_d  = S_HOLD;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    // Held instruction is abandoned, so it is not counted.
                    pc_d    = redirect_pc;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_STEP;
                    cnt_d   = cnt_q + CNT_ONE;
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
                req_d   = 1'b0;
            end
        endcase
    end

    instr_field_decode u_decode (
        .instr     (instr_q),
        .opcode    (opcode),
        .fcode     (fcode),
        .rs        (rs),
        .rt        (rt),
        .imm       (imm),
        .undefined (undefined)
    );

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + PC_STEP;
    assign illegal     = instr_valid && undefined;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test of instr_fetch_unit with hand-computed
// expectations. Inputs change 1 time unit after a rising edge; outputs are
// sampled at that same point, after the edge has settled.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [1:0]  opcode;
    logic [3:0]  fcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        illegal;
    logic [15:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .opcode         (opcode),
        .fcode          (fcode),
        .rs             (rs),
        .rt             (rt),
        .imm            (imm),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .illegal        (illegal),
        .fetch_count    (fetch_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        imem_ready     = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        #3;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_count", {16'd0, fetch_count}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // back-to-back fetch, ready tied high
        imem_ready = 1'b1;
        imem_rdata = 32'h4400_0000;
        tick();
        check("t1_req0", {31'd0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t1_valid1", {31'd0, instr_valid}, 32'd1);
        check("t1_opcode", {30'd0, opcode}, 32'd1);
        check("t1_fcode", {28'd0, fcode}, 32'd1);
        check("t1_illegal", {31'd0, illegal}, 32'd0);
        check("t1_req_hold", {31'd0, imem_req}, 32'd0);
        check("t1_count0", {16'd0, fetch_count}, 32'd0);
        tick();
        check("t1_addr4", imem_addr, 32'h4);
        check("t1_count1", {16'd0, fetch_count}, 32'd1);
        check("t1_valid_drop", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t1_pc_out4", pc_out, 32'h4);
        check("t1_pc_plus4", pc_plus4, 32'h8);
        tick();
        check("t1_addr8", imem_addr, 32'h8);
        check("t1_count2", {16'd0, fetch_count}, 32'd2);

        // memory wait: three cycles of ready low
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_addr_held", imem_addr, 32'h8);
            check("t2_req_held", {31'd0, imem_req}, 32'd1);
            check("t2_valid_low", {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hC400_0010;
        tick();
        check("t2_capture", instr, 32'hC400_0010);
        check("t2_valid", {31'd0, instr_valid}, 32'd1);
        check("t2_pc_out", pc_out, 32'h8);

        // stall in S_HOLD
        stall = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_instr", instr, 32'hC400_0010);
            check("t3_pc_out", pc_out, 32'h8);
            check("t3_valid", {31'd0, instr_valid}, 32'd1);
            check("t3_req", {31'd0, imem_req}, 32'd0);
            check("t3_addr", imem_addr, 32'h8);
            check("t3_count", {16'd0, fetch_count}, 32'd2);
        end
        check("t3_imm", {16'd0, imm}, 32'h10);
        stall = 1'b0;
        tick();
        check("t3_addr_adv", imem_addr, 32'hC);
        check("t3_count3", {16'd0, fetch_count}, 32'd3);

        // redirect coincident with ready in S_REQ
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        imem_rdata     = 32'h1234_5678;
        tick();
        redirect_valid = 1'b0;
        check("t4_req_drop", {31'd0, imem_req}, 32'd0);
        check("t4_valid", {31'd0, instr_valid}, 32'd0);
        check("t4_instr_kept", instr, 32'hC400_0010);
        check("t4_count", {16'd0, fetch_count}, 32'd3);
        imem_rdata = 32'h8C00_0000;
        tick();
        check("t4_req_back", {31'd0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h100);
        check("t4_valid_wait", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t4_capture", instr, 32'h8C00_0000);
        check("t4_opcode", {30'd0, opcode}, 32'd2);
        check("t4_fcode", {28'd0, fcode}, 32'd3);
        check("t4_illegal", {31'd0, illegal}, 32'd0);
        check("t4_pc_out", pc_out, 32'h100);

        // redirect and stall together in S_HOLD
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        stall          = 1'b1;
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check("t5_valid", {31'd0, instr_valid}, 32'd0);
        check("t5_req", {31'd0, imem_req}, 32'd1);
        check("t5_addr", imem_addr, 32'h200);
        check("t5_count", {16'd0, fetch_count}, 32'd3);

        // undefined encoding
        imem_rdata = 32'h2400_0000;
        tick();
        check("t6_fcode", {28'd0, fcode}, 32'd9);
        check("t6_illegal", {31'd0, illegal}, 32'd1);
        check("t6_pc_out", pc_out, 32'h200);
        tick();
        check("t6_illegal_drop", {31'd0, illegal}, 32'd0);
        check("t6_addr", imem_addr, 32'h204);
        check("t6_count", {16'd0, fetch_count}, 32'd4);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("t7_req_drop", {31'd0, imem_req}, 32'd0);
        imem_rdata = 32'h4400_0000;
        tick();
        check("t7_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t7_pc_out", pc_out, 32'hFFFF_FFFC);
        check("t7_pc_plus4", pc_plus4, 32'h0);
        tick();
        check("t7_wrap_addr", imem_addr, 32'h0);
        check("t7_count", {16'd0, fetch_count}, 32'd5);
        tick();
        tick();
        tick();
        check("t8_pre_valid", {31'd0, instr_valid}, 32'd1);
        check("t8_pre_pc_out", pc_out, 32'h4);

        // async reset while holding
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t8_valid", {31'd0, instr_valid}, 32'd0);
        check("t8_pc_out", pc_out, 32'h0);
        check("t8_count", {16'd0, fetch_count}, 32'd0);
        check("t8_req", {31'd0, imem_req}, 32'd0);
        check("t8_instr", instr, 32'h0);
        tick();
        check("t8_hold_valid", {31'd0, instr_valid}, 32'd0);
        rst   = 1'b0;
        stall = 1'b0;
        tick();
        check("t8_restart_req", {31'd0, imem_req}, 32'd1);
        check("t8_restart_addr", imem_addr, 32'h0);
        check("t8_restart_valid", {31'd0, instr_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
